// File: rtl/alu_issue_pkg.sv
// Shared opcode encodings and FSM state type for the round-robin ALU issue controller.
package alu_issue_pkg;

    localparam logic [3:0] OP_ROL = 4'd0;
    localparam logic [3:0] OP_ROR = 4'd1;
    localparam logic [3:0] OP_MAX = 4'd2;
    localparam logic [3:0] OP_MIN = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;

    // The only opcode whose EXEC phase lasts longer than one cycle.
    localparam logic [3:0] DIV_OPCODE = OP_DIV;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr_i, wrapping.
module alu_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDW-1:0]     rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_idx_o
);

    logic           found;
    logic [IDW-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                grant_idx_o    = cand;
            end
        end
    end

endmodule

// File: rtl/alu_rr_issue_ctrl.sv
// Round-robin issue controller sharing one ALU between NUM_REQ requesters.
// Optional ALU_ISSUE_FLAGS_EN adds registered resp_zero/resp_sign/resp_carry outputs.
module alu_rr_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int W          = 64,
    parameter int DIV_CYCLES = 8,
    parameter int IDW        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_opcode,
    input  logic [W*NUM_REQ-1:0] req_a,
    input  logic [W*NUM_REQ-1:0] req_b,
    input  logic [5*NUM_REQ-1:0] req_shift,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [W-1:0]         resp_result,
`ifdef ALU_ISSUE_FLAGS_EN
    output logic                 resp_zero,
    output logic                 resp_sign,
    output logic                 resp_carry,
`endif
    output logic                 busy
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    state_t         state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [CW-1:0]  cnt_q;
    logic           resp_valid_q;
    logic [IDW-1:0] resp_id_q;
    logic [W-1:0]   resp_result_q;

    logic [3:0]     op_code_q;
    logic [W-1:0]   op_a_q;
    logic [W-1:0]   op_b_q;
    logic [4:0]     op_shift_q;
    logic [IDW-1:0] op_id_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_idx;
    logic               grant_fire;

    logic [3:0]   sel_op_d;
    logic [W-1:0] sel_a_d;
    logic [W-1:0] sel_b_d;
    logic [4:0]   sel_shift_d;

    logic [W-1:0] alu_res;
    int           rot_amt;

    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx)
    );

    // A pending response blocks new grants unless it drains on this very edge.
    assign req_ready  = (!rst && state_q == IDLE && (!resp_valid_q || resp_ready)) ? pick_grant : '0;
    assign grant_fire = |req_ready;

    always_comb begin
        sel_op_d    = '0;
        sel_a_d     = '0;
        sel_b_d     = '0;
        sel_shift_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_op_d    = req_opcode[i*4 +: 4];
                sel_a_d     = req_a[i*W +: W];
                sel_b_d     = req_b[i*W +: W];
                sel_shift_d = req_shift[i*5 +: 5];
            end
        end
    end

    always_comb begin
        alu_res = '0;
        rot_amt = int'(op_shift_q) % W;
        case (op_code_q)
            OP_ROL:  alu_res = (op_a_q << rot_amt) | (op_a_q >> (W - rot_amt));
            OP_ROR:  alu_res = (op_a_q >> rot_amt) | (op_a_q << (W - rot_amt));
            OP_MAX:  alu_res = (op_a_q > op_b_q) ? op_a_q : op_b_q;
            OP_MIN:  alu_res = (op_a_q < op_b_q) ? op_a_q : op_b_q;
            OP_OR:   alu_res = op_a_q | op_b_q;
            OP_DIV:  alu_res = (op_b_q == '0) ? '0 : op_a_q / op_b_q;
            OP_SUB:  alu_res = op_a_q - op_b_q;
            OP_XOR:  alu_res = op_a_q ^ op_b_q;
            default: alu_res = '0;
        endcase
    end

    // NOTE: operand registers carry no reset; they are only read in EXEC, which is entered after a capture.
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            op_code_q  <= sel_op_d;
            op_a_q     <= sel_a_d;
            op_b_q     <= sel_b_d;
            op_shift_q <= sel_shift_d;
            op_id_q    <= pick_idx;
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic resp_zero_q;
    logic resp_sign_q;
    logic resp_carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_zero_q  <= 1'b0;
            resp_sign_q  <= 1'b0;
            resp_carry_q <= 1'b0;
        end else if (state_q == EXEC && cnt_q == '0) begin
            resp_zero_q  <= (alu_res == '0);
            resp_sign_q  <= alu_res[W-1];
            resp_carry_q <= (op_code_q == OP_SUB) && (op_a_q < op_b_q);
        end
    end

    assign resp_zero  = resp_zero_q;
    assign resp_sign  = resp_sign_q;
    assign resp_carry = resp_carry_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
        end else begin
            if (resp_valid_q && resp_ready) begin
                resp_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        rr_ptr_q <= IDW'((int'(pick_idx) + 1) % NUM_REQ);
                        cnt_q    <= (sel_op_d == DIV_OPCODE) ? CW'(DIV_CYCLES - 1) : '0;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        resp_valid_q  <= 1'b1;
                        resp_id_q     <= op_id_q;
                        resp_result_q <= alu_res;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign busy        = (state_q != IDLE) || resp_valid_q;

endmodule

// File: tb/tb_alu_rr_issue_ctrl.sv
// Directed self-checking bench for alu_rr_issue_ctrl (4 requesters, 64-bit, DIV_CYCLES=8).
module tb_alu_rr_issue_ctrl;
    import alu_issue_pkg::*;

    localparam int NR  = 4;
    localparam int W   = 64;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [4*NR-1:0] req_opcode = '0;
    logic [W*NR-1:0] req_a = '0;
    logic [W*NR-1:0] req_b = '0;
    logic [5*NR-1:0] req_shift = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [IDW-1:0]  resp_id;
    logic [W-1:0]    resp_result;
    logic            busy;
`ifdef ALU_ISSUE_FLAGS_EN
    logic            resp_zero;
    logic            resp_sign;
    logic            resp_carry;
`endif

    int errors = 0;
    int checks = 0;

    alu_rr_issue_ctrl #(
        .NUM_REQ    (NR),
        .W          (W),
        .DIV_CYCLES (8),
        .IDW        (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_shift   (req_shift),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
`ifdef ALU_ISSUE_FLAGS_EN
        .resp_zero   (resp_zero),
        .resp_sign   (resp_sign),
        .resp_carry  (resp_carry),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [4:0] sh);
        req_opcode[idx*4 +: 4] = op;
        req_a[idx*W +: W]      = a;
        req_b[idx*W +: W]      = b;
        req_shift[idx*5 +: 5]  = sh;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Drives one request, waits (bounded) for grant and response; lat=-1 if never granted/answered.
    task automatic issue(input int idx, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh,
                         output logic [W-1:0] res, output logic [IDW-1:0] id, output int lat);
        set_req(idx, op, a, b, sh);
        req_valid[idx] = 1'b1;
        resp_ready     = 1'b1;
        lat            = -1;
        res            = '0;
        id             = '0;
        #1;
        for (int c = 0; c < 20 && !req_ready[idx]; c++) step();
        if (req_ready[idx]) begin
            step();
            req_valid[idx] = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                step();
                if (resp_valid) begin
                    lat = c;
                    break;
                end
            end
            res = resp_result;
            id  = resp_id;
            step();
        end else begin
            req_valid[idx] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        step();
        step();
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
        checks++;
        if (resp_id !== 2'd0 || resp_result !== 64'd0) begin
            errors++;
            $display("FAIL reset_resp: got id=%0d result=%h expected 0 0", resp_id, resp_result);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_sub();
        do_reset();
        set_req(0, OP_SUB, 64'd5, 64'd7, 5'd0);
        req_valid[0] = 1'b1;
        resp_ready   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL sub_grant: got %b expected 0001", req_ready);
        end
        step();
        req_valid[0] = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sub_exec: got valid=%b ready=%b busy=%b expected 0 0000 1",
                     resp_valid, req_ready, busy);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++;
            $display("FAIL sub_resp: got valid=%b id=%0d result=%h expected 1 0 fffffffffffffffe",
                     resp_valid, resp_id, resp_result);
        end
`ifdef ALU_ISSUE_FLAGS_EN
        checks++;
        if (resp_carry !== 1'b1 || resp_sign !== 1'b1 || resp_zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_flags: got c=%b s=%b z=%b expected 1 1 0", resp_carry, resp_sign, resp_zero);
        end
`endif
        step();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sub_drain: got valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_rr_order();
        logic [W-1:0] a_v [NR];
        logic [W-1:0] b_v [NR];
        int exp_id;
        int nxt;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_v[i] = 64'h0123_4567_89AB_CDEF + 64'(i * 17);
            b_v[i] = 64'hF0F0_0000_FFFF_1234 >> i;
            set_req(i, OP_XOR, a_v[i], b_v[i], 5'd0);
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        #1;
        for (int g = 0; g < 8; g++) begin
            exp_id = g % NR;
            checks++;
            if (req_ready !== 4'(1 << exp_id)) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, 4'(1 << exp_id));
            end
            step();
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL rr_exec_ready%0d: got %b expected 0000", g, req_ready);
            end
            step();
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== IDW'(exp_id) || resp_result !== (a_v[exp_id] ^ b_v[exp_id])) begin
                errors++;
                $display("FAIL rr_resp%0d: got valid=%b id=%0d result=%h expected 1 %0d %h",
                         g, resp_valid, resp_id, resp_result, exp_id, a_v[exp_id] ^ b_v[exp_id]);
            end
        end
        nxt = 0;
        checks++;
        if (req_ready !== 4'(1 << nxt)) begin
            errors++;
            $display("FAIL rr_drain_grant: got %b expected 0001", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_div();
        logic [W-1:0]   res;
        logic [IDW-1:0] id;
        int             lat;
        issue(2, OP_DIV, 64'd100, 64'd7, 5'd0, res, id, lat);
        checks++;
        if (lat !== 8 || res !== 64'd14 || id !== 2'd2) begin
            errors++;
            $display("FAIL div_100_7: got lat=%0d result=%0d id=%0d expected 8 14 2", lat, res, id);
        end
        issue(2, OP_DIV, 64'd100, 64'd0, 5'd0, res, id, lat);
        checks++;
        if (lat !== 8 || res !== 64'd0 || id !== 2'd2) begin
            errors++;
            $display("FAIL div_by_zero: got lat=%0d result=%0d id=%0d expected 8 0 2", lat, res, id);
        end
    endtask

    task automatic test_backpressure();
        set_req(3, OP_OR, 64'hF0, 64'h0F, 5'd0);
        req_valid[3] = 1'b1;
        resp_ready   = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_grant3: got %b expected 1000", req_ready);
        end
        step();
        req_valid[3] = 1'b0;
        set_req(1, OP_MAX, 64'd3, 64'd9, 5'd0);
        req_valid[1] = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_result !== 64'hFF) begin
                errors++;
                $display("FAIL bp_hold%0d: got ready=%b valid=%b id=%0d result=%h expected 0000 1 3 ff",
                         c, req_ready, resp_valid, resp_id, resp_result);
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_drain_grant: got %b expected 0010", req_ready);
        end
        step();
        req_valid[1] = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_cleared: got %b expected 0", resp_valid);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 64'd9) begin
            errors++;
            $display("FAIL bp_next_resp: got valid=%b id=%0d result=%0d expected 1 1 9",
                     resp_valid, resp_id, resp_result);
        end
        step();
    endtask

    task automatic test_rotate_misc();
        logic [W-1:0]   res;
        logic [IDW-1:0] id;
        int             lat;
        issue(0, OP_ROL, 64'h8000_0000_0000_0001, 64'd0, 5'd1, res, id, lat);
        checks++;
        if (res !== 64'h3 || lat !== 1) begin
            errors++;
            $display("FAIL rol1: got result=%h lat=%0d expected 3 1", res, lat);
        end
        issue(0, OP_ROR, 64'hDEAD_BEEF_0123_4567, 64'd0, 5'd0, res, id, lat);
        checks++;
        if (res !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL ror0: got %h expected deadbeef01234567", res);
        end
        issue(3, OP_ROR, 64'd1, 64'd0, 5'd4, res, id, lat);
        checks++;
        if (res !== 64'h1000_0000_0000_0000 || id !== 2'd3) begin
            errors++;
            $display("FAIL ror4: got result=%h id=%0d expected 1000000000000000 3", res, id);
        end
        issue(1, OP_MAX, 64'h8000_0000_0000_0000, 64'd1, 5'd0, res, id, lat);
        checks++;
        if (res !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL max_unsigned: got %h expected 8000000000000000", res);
        end
        issue(2, OP_MIN, 64'h8000_0000_0000_0000, 64'd1, 5'd0, res, id, lat);
        checks++;
        if (res !== 64'd1) begin
            errors++;
            $display("FAIL min_unsigned: got %h expected 1", res);
        end
        issue(0, 4'd12, 64'hFF, 64'hFF, 5'd3, res, id, lat);
        checks++;
        if (res !== 64'd0 || lat !== 1) begin
            errors++;
            $display("FAIL opcode12: got result=%h lat=%0d expected 0 1", res, lat);
        end
    endtask

    task automatic test_reset_mid_div();
        bit saw_resp;
        set_req(2, OP_DIV, 64'd1000, 64'd3, 5'd0);
        req_valid[2] = 1'b1;
        resp_ready   = 1'b1;
        for (int c = 0; c < 20 && !req_ready[2]; c++) step();
        step();
        req_valid[2] = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        saw_resp = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (resp_valid !== 1'b0 || busy !== 1'b0) saw_resp = 1'b1;
            step();
        end
        checks++;
        if (saw_resp !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_div: got response/busy after reset expected none");
        end
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rst_ptr_grant: got %b expected 0010", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sub();
        test_rr_order();
        test_div();
        test_backpressure();
        test_rotate_misc();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
